cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Run/halt/single-step sequencer for the `computer` CPU. It gates CPU progress through a clock-enable driven from the four board switches.
- It also multiplexes one nibble of regA, regB or the ALU bus onto the four LEDs.
- Sits in top_final between the switches/LEDs and the CPU instance. The CPU consumes `o_cpu_ce` as its clock enable.

Parameters:
- DEBOUNCE_CYCLES, 250000, number of stable clk cycles required before a switch level is accepted (10 ms at 25 MHz); must be >= 2.
- CNT_W, 18, width of the debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  in  1  system clock, sole clock domain.
- reset  in  1  synchronous, active-high reset.
- i_sw_run  in  1  raw switch 1; each press toggles RUN/HALT.
- i_sw_step  in  1  raw switch 2; each press issues one CPU step while halted.
- i_sw_sel  in  1  raw switch 3; each press advances the display source.
- i_sw_nib  in  1  raw switch 4; each press toggles the displayed nibble.
- i_regA_bus  in  8  CPU regA output.
- i_regB_bus  in  8  CPU regB output.
- i_alu_bus  in  8  CPU ALU output.
- o_cpu_ce  out  1  CPU clock enable, registered.
- o_state  out  2  current FSM state (HALT=0, RUN=1, STEP=2).
- o_led  out  4  displayed nibble, registered.

Behaviour:

One clock domain: `clk`. Reset is synchronous and active-high on `reset`.

Reset values:
- state=HALT, o_cpu_ce=0, o_led=0.
- sel=A (0), nib=low (0).
- All synchronizer flops, debounced levels, counters and press pulses are 0.

Switch path (per switch):
- 2-FF synchronizer feeds a debouncer.
- If the synced value equals the debounced level, the counter clears.
- Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value and the counter clears.
- A press is a one-cycle pulse on each debounced 0->1 transition. Releases produce nothing.
- Latency: after a raw input settles, its press pulse is high in exactly one cycle, DEBOUNCE_CYCLES+3 clk edges after the first edge that samples the new level.
- A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.

FSM (state register; o_cpu_ce is a registered decode of the next state):
- HALT:
  - run press -> RUN.
  - Otherwise step press -> STEP.
  - Run and step pressed in the same cycle: RUN wins and the step is dropped.
- RUN:
  - run press -> HALT.
  - Step presses are ignored.
- STEP: unconditionally -> HALT next cycle.
  - Any run or step press arriving while in STEP is dropped.
- o_cpu_ce=1 exactly in cycles where the state register is RUN or STEP.
  - One step press therefore yields exactly one o_cpu_ce-high cycle.
  - Entering RUN makes o_cpu_ce high from the cycle after the press pulse.
  - Leaving RUN makes o_cpu_ce low from the cycle after the press pulse.
- Reset asserted in any state, including mid-STEP: state=HALT and o_cpu_ce=0 on the next edge, with no residual step.

Display:
- sel press: A -> B -> ALU -> A; the encoding 3 is never reached.
- nib press toggles the nibble between low [3:0] and high [7:4].
- o_led is registered: one cycle after a bus change, or after a sel/nib update, o_led reflects it.
- Display controls are independent of the FSM and operate in every state.
- sel and nib pressed in the same cycle: both update.

Optional Feature:
- Macro: CPU_CYCLE_CNT_EN.
- Defined:
  - Adds output `o_cycle_cnt` (16 bits).
  - It increments on every cycle where o_cpu_ce=1, wraps 0xFFFF -> 0x0000, and is cleared by reset.
  - It is visible the cycle after the counted enable.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - the state encoding (HALT=2'd0, RUN=2'd1, STEP=2'd2);
  - the display-source encoding (SRC_A=2'd0, SRC_B=2'd1, SRC_ALU=2'd2);
  - the default DEBOUNCE_CYCLES.
- Sub-module sw_debounce (parameters DEBOUNCE_CYCLES and CNT_W; ports clk, reset, i_raw, o_level, o_press) holds the synchronizer, debounce counter and edge detector. It is instantiated four times in cpu_run_ctrl.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset held 3 cycles, then released with all inputs 0 -> o_state=0, o_cpu_ce=0, o_led=0 for 20 cycles.
- i_sw_step held 1 for 10 cycles from HALT -> exactly one o_cpu_ce pulse, 1 cycle wide, o_state sequence 0,2,0. A second hold gives a second single pulse.
- i_sw_run pressed -> o_cpu_ce high continuously. A step press during RUN changes nothing. A second run press returns to HALT with o_cpu_ce=0 the next cycle.
- i_sw_run glitch of 3 cycles high -> no state change. A 2-cycle dropout during a held press does not create a second press.
- i_regA_bus=8'hA5, i_regB_bus=8'h3C, i_alu_bus=8'hF0:
  - o_led=4'h5 initially;
  - after one nib press, 4'hA;
  - after one sel press, 4'h3;
  - after another sel press, 4'hF;
  - after another sel press, 4'hA (back to regA high).
- Run and step press pulses in the same cycle in HALT -> RUN, no STEP. Reset asserted in the STEP cycle -> HALT next cycle with o_cpu_ce=0. With CPU_CYCLE_CNT_EN, starting from reset, 3 steps and then 0x10000 RUN cycles -> o_cycle_cnt=0x0003.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: state and display-source encodings shared by the run/halt/step controller
package cpu_ctrl_pkg;
    typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2} state_t;
    typedef enum logic [1:0] {SRC_A = 2'd0, SRC_B = 2'd1, SRC_ALU = 2'd2} src_t;
    localparam int DEBOUNCE_DEFAULT = 250000;
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-FF synchronizer, stable-count debouncer and rising-edge press pulse
import cpu_ctrl_pkg::*;
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);
    logic s1, s2, lq;
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            {s1, s2, lq, o_level, o_press} <= '0;
            cnt <= '0;
        end else begin
            s1 <= i_raw;
            s2 <= s1;
            lq <= o_level;
            o_press <= o_level & ~lq;
            if (s2 == o_level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt <= '0;
                o_level <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/halt/single-step clock-enable sequencer with nibble LED display
// Define CPU_CYCLE_CNT_EN to add the o_cycle_cnt enabled-cycle counter output.
import cpu_ctrl_pkg::*;
module cpu_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_sw_run,
    input  logic       i_sw_step,
    input  logic       i_sw_sel,
    input  logic       i_sw_nib,
    input  logic [7:0] i_regA_bus,
    input  logic [7:0] i_regB_bus,
    input  logic [7:0] i_alu_bus,
    output logic       o_cpu_ce,
    output logic [1:0] o_state,
`ifdef CPU_CYCLE_CNT_EN
    output logic [15:0] o_cycle_cnt,
`endif
    output logic [3:0] o_led
);
    state_t state;
    src_t sel;
    logic nib;
    logic [3:0] raw, level, press, pr;
    logic [7:0] bus;
    assign raw = {i_sw_nib, i_sw_sel, i_sw_step, i_sw_run};
    for (genvar i = 0; i < 4; i++) begin : g_sw
        sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
            .clk(clk), .reset(reset), .i_raw(raw[i]), .o_level(level[i]), .o_press(press[i])
        );
    end
    // a press always coincides with a high debounced level
    assign pr = press & level;
    assign o_state = state;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HALT;
            o_cpu_ce <= 1'b0;
        end else begin
            case (state)
                HALT: begin
                    state <= pr[0] ? RUN : pr[1] ? STEP : HALT;
                    o_cpu_ce <= pr[0] | pr[1];
                end
                RUN: begin
                    state <= pr[0] ? HALT : RUN;
                    o_cpu_ce <= ~pr[0];
                end
                default: begin
                    state <= HALT;
                    o_cpu_ce <= 1'b0;
                end
            endcase
        end
    end
    always_comb bus = (sel == SRC_A) ? i_regA_bus : (sel == SRC_B) ? i_regB_bus : i_alu_bus;
    always_ff @(posedge clk) begin
        if (reset) begin
            sel <= SRC_A;
            nib <= 1'b0;
            o_led <= 4'd0;
        end else begin
            if (pr[2]) sel <= (sel == SRC_A) ? SRC_B : (sel == SRC_B) ? SRC_ALU : SRC_A;
            nib <= nib ^ pr[3];
            o_led <= nib ? bus[7:4] : bus[3:0];
        end
    end
`ifdef CPU_CYCLE_CNT_EN
    always_ff @(posedge clk) o_cycle_cnt <= reset ? 16'd0 : o_cycle_cnt + {15'd0, o_cpu_ce};
`endif
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed, table-driven and randomized checks against a behavioural model
module tb_cpu_run_ctrl;
    localparam int DEB = 4;
    typedef struct {bit nib; bit sel; logic [3:0] exp;} vec_t;

    logic clk = 0, reset = 1;
    logic sw_run = 0, sw_step = 0, sw_sel = 0, sw_nib = 0;
    logic [7:0] a = 0, b = 0, alu = 0;
    logic cpu_ce;
    logic [1:0] state;
    logic [3:0] led;
`ifdef CPU_CYCLE_CNT_EN
    logic [15:0] cyc;
`endif
    int errors = 0, checks = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .i_sw_run(sw_run), .i_sw_step(sw_step), .i_sw_sel(sw_sel), .i_sw_nib(sw_nib),
        .i_regA_bus(a), .i_regB_bus(b), .i_alu_bus(alu),
        .o_cpu_ce(cpu_ce), .o_state(state),
`ifdef CPU_CYCLE_CNT_EN
        .o_cycle_cnt(cyc),
`endif
        .o_led(led)
    );

    function automatic void check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference model: a switch level flips once the synchronised stream (raw delayed two
    // samples) has disagreed with it for DEB consecutive cycles; presses are rising levels.
    bit [3:0] hist [DEB+1];
    bit [3:0] m_lvl, m_lvq, m_press;
    int m_state, m_sel, m_nib, m_led, m_ce, m_cnt;
    always @(posedge clk) begin
        automatic bit [3:0] raw = {sw_nib, sw_sel, sw_step, sw_run};
        automatic bit [3:0] nl = m_lvl;
        automatic logic [7:0] bus = (m_sel == 0) ? a : (m_sel == 1) ? b : alu;
        automatic int ns;
        if (reset) begin
            for (int j = 0; j <= DEB; j++) hist[j] = 0;
            m_lvl = 0; m_lvq = 0; m_press = 0;
            m_state = 0; m_sel = 0; m_nib = 0; m_led = 0; m_ce = 0; m_cnt = 0;
        end else begin
            for (int s = 0; s < 4; s++) begin
                automatic bit flip = 1;
                for (int j = 1; j <= DEB; j++) if (hist[j][s] == m_lvl[s]) flip = 0;
                if (flip) nl[s] = ~m_lvl[s];
            end
            if (m_state == 0) ns = m_press[0] ? 1 : m_press[1] ? 2 : 0;
            else if (m_state == 1) ns = m_press[0] ? 0 : 1;
            else ns = 0;
            m_cnt = (m_cnt + m_ce) % 65536;
            m_ce = (ns != 0) ? 1 : 0;
            m_state = ns;
            m_led = m_nib != 0 ? int'(bus[7:4]) : int'(bus[3:0]);
            if (m_press[2]) m_sel = (m_sel + 1) % 3;
            if (m_press[3]) m_nib = 1 - m_nib;
            m_press = m_lvl & ~m_lvq;
            m_lvq = m_lvl;
            m_lvl = nl;
            for (int j = DEB; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = raw;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mask(int m, logic v);
        if (m[0]) sw_run = v;
        if (m[1]) sw_step = v;
        if (m[2]) sw_sel = v;
        if (m[3]) sw_nib = v;
    endtask

    task automatic hold(int m, int hi, int lo);
        set_mask(m, 1);
        tick(hi);
        set_mask(m, 0);
        tick(lo);
    endtask

    task automatic observe(int m, int rel, int n, output int hi, output int first,
                           output int nchg, output int saw, output int last);
        int prev;
        hi = 0; first = 0; nchg = 0; saw = 0; prev = int'(state);
        set_mask(m, 1);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == rel) set_mask(m, 0);
            if (cpu_ce) begin
                hi++;
                if (first == 0) first = c;
            end
            if (int'(state) != prev) nchg++;
            if (state == 2'd2) saw = 1;
            prev = int'(state);
        end
        last = int'(state);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int hi, first, nchg, saw, last, n;
        vecs[0] = '{0, 0, 4'h5};
        vecs[1] = '{1, 0, 4'hA};
        vecs[2] = '{0, 1, 4'h3};
        vecs[3] = '{0, 1, 4'hF};
        vecs[4] = '{0, 1, 4'hA};
        vecs[5] = '{1, 1, 4'hC};

        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    check("model_state", int'(state), m_state);
                    check("model_ce", int'(cpu_ce), m_ce);
                    check("model_led", int'(led), m_led);
`ifdef CPU_CYCLE_CNT_EN
                    check("model_cycles", int'(cyc), m_cnt);
`endif
                end
            end
        join_none

        tick(1);
        chk_en = 1;
        tick(2);
        reset = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("reset_state", int'(state), 0);
            check("reset_ce", int'(cpu_ce), 0);
            check("reset_led", int'(led), 0);
        end

        for (int k = 0; k < 2; k++) begin
            tick(1);
            observe(2, 10, 40, hi, first, nchg, saw, last);
            check("step_ce_cycles", hi, 1);
            check("step_latency", first, DEB + 5);
            check("step_changes", nchg, 2);
            check("step_seen", saw, 1);
            check("step_end", last, 0);
        end

        tick(1);
        observe(1, 10, 40, hi, first, nchg, saw, last);
        check("run_enter_state", last, 1);
        check("run_enter_ce", hi, 40 - (DEB + 5) + 1);
        tick(1);
        observe(2, 10, 40, hi, first, nchg, saw, last);
        check("run_step_ignored", nchg, 0);
        check("run_step_ce", hi, 40);
        tick(1);
        observe(1, 10, 40, hi, first, nchg, saw, last);
        check("run_leave_state", last, 0);
        check("run_leave_ce", hi, DEB + 4);

        tick(1);
        observe(1, 4, 30, hi, first, nchg, saw, last);
        check("glitch_changes", nchg, 0);
        check("glitch_ce", hi, 0);

        set_mask(1, 1); tick(10);
        set_mask(1, 0); tick(2);
        set_mask(1, 1); tick(10);
        set_mask(1, 0); tick(20);
        check("dropout_state", int'(state), 1);
        hold(1, 10, 20);
        check("dropout_off", int'(state), 0);

        tick(1);
        observe(3, 10, 40, hi, first, nchg, saw, last);
        check("both_no_step", saw, 0);
        check("both_run", last, 1);
        tick(1);
        observe(1, 10, 40, hi, first, nchg, saw, last);
        check("both_halt", last, 0);

        tick(1);
        sw_step = 1;
        n = 0;
        while (state != 2'd2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("mid_step_reached", int'(state), 2);
        reset = 1;
        @(negedge clk);
        check("mid_reset_state", int'(state), 0);
        check("mid_reset_ce", int'(cpu_ce), 0);
        sw_step = 0;
        tick(2);
        reset = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("post_reset_state", int'(state), 0);
            check("post_reset_ce", int'(cpu_ce), 0);
        end

        a = 8'hA5; b = 8'h3C; alu = 8'hF0;
        tick(2);
        for (int v = 0; v < 6; v++) begin
            hold((vecs[v].nib ? 8 : 0) | (vecs[v].sel ? 4 : 0), 10, 20);
            check($sformatf("led_vec%0d", v), int'(led), int'(vecs[v].exp));
        end
        b = 8'h7E;
        tick(1);
        check("led_bus_change", int'(led), 4'hE);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(9, 0) == 0) sw_run = ~sw_run;
            if ($urandom_range(9, 0) == 0) sw_step = ~sw_step;
            if ($urandom_range(9, 0) == 0) sw_sel = ~sw_sel;
            if ($urandom_range(9, 0) == 0) sw_nib = ~sw_nib;
            if ($urandom_range(7, 0) == 0) a = 8'($urandom);
            if ($urandom_range(7, 0) == 0) b = 8'($urandom);
            if ($urandom_range(7, 0) == 0) alu = 8'($urandom);
            tick(1);
        end
        set_mask(15, 0);
        tick(30);

`ifdef CPU_CYCLE_CNT_EN
        reset = 1;
        tick(2);
        reset = 0;
        for (int k = 0; k < 3; k++) hold(2, 10, 20);
        check("cnt_after_steps", int'(cyc), 3);
        sw_run = 1;
        n = 0;
        while (!cpu_ce && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("cnt_run_entered", int'(cpu_ce), 1);
        for (int c = 0; c < 65536; c++) begin
            @(negedge clk);
            if (c == 10) sw_run = 0;
        end
        check("cnt_wrap", int'(cyc), 3);
        check("cnt_still_running", int'(cpu_ce), 1);
`endif

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
